// File: rtl/sram_like_bridge.sv
// sram_like_bridge
// Bridges a CPU-side SRAM-style port onto an SRAM-like bus with
// address/data handshakes. Writes are posted into a small FIFO so the CPU
// does not wait for them. Reads stall the CPU until the FIFO has drained
// and the read data has come back, which keeps read-after-write ordering.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   sram_en, sram_wen           CPU access valid, byte write enables (0 = read)
//   sram_addr, sram_wdata       CPU byte address, write data
//   sram_rdata, stall           read data to CPU, hold-access request to CPU
//   longest_stall               pipeline freeze; CPU access is held while 1
//   req, wr, size, addr, wdata  SRAM-like request channel
//   addr_ok, data_ok, rdata     SRAM-like address accept, data done, read data
//   wbuf_empty                  FIFO empty and no write on the bus
//
// state  | meaning
// IDLE   | no bus transfer; pick FIFO head first, then a pending read
// WADDR  | write request on bus, waiting for addr_ok
// WDATA  | write address accepted, waiting for data_ok
// RADDR  | read request on bus, waiting for addr_ok
// RDATA  | read address accepted, waiting for data_ok
// RDONE  | read data registered, CPU released; wait for freeze to lift
module sram_like_bridge #(
    parameter int AW         = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sram_en,
    input  logic [3:0]    sram_wen,
    input  logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_wdata,
    output logic [31:0]   sram_rdata,
    output logic          stall,
    input  logic          longest_stall,
    output logic          req,
    output logic          wr,
    output logic [1:0]    size,
    output logic [AW-1:0] addr,
    output logic [31:0]   wdata,
    input  logic          addr_ok,
    input  logic          data_ok,
    input  logic [31:0]   rdata,
    output logic          wbuf_empty
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RDATA, RDONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_taken;

    logic [AW-1:0] mem_addr  [WBUF_DEPTH];
    logic [31:0]   mem_wdata [WBUF_DEPTH];
    logic [1:0]    mem_size  [WBUF_DEPTH];

    logic wr_req, rd_req, full, push, pop, rd_capture;

    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        case (wen)
            4'b0011, 4'b1100:                   return 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            default:                            return 2'd2;
        endcase
    endfunction

    assign wr_req = sram_en & (|sram_wen);
    assign rd_req = sram_en & ~(|sram_wen);
    assign full   = (count == CW'(WBUF_DEPTH));
    // wr_taken marks a frozen write that is already queued, so the held
    // access is not pushed again on every frozen cycle.
    assign push   = wr_req & ~full & ~wr_taken;

    assign stall      = (wr_req & full & ~wr_taken) | (rd_req & (state != RDONE));
    assign wbuf_empty = (count == '0) & (state != WADDR) & (state != WDATA);

    always_comb begin
        state_nxt  = state;
        req        = 1'b0;
        wr         = 1'b0;
        size       = 2'd0;
        addr       = '0;
        wdata      = '0;
        pop        = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0)
                    state_nxt = WADDR;
                else if (rd_req)
                    state_nxt = RADDR;
            end
            WADDR: begin
                req   = 1'b1;
                wr    = 1'b1;
                size  = mem_size[rd_ptr];
                addr  = mem_addr[rd_ptr];
                wdata = mem_wdata[rd_ptr];
                if (addr_ok && data_ok) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end else if (addr_ok) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                if (data_ok) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RADDR: begin
                req  = 1'b1;
                size = 2'd2;
                addr = sram_addr;
                if (addr_ok && data_ok) begin
                    rd_capture = 1'b1;
                    state_nxt  = RDONE;
                end else if (addr_ok) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (data_ok) begin
                    rd_capture = 1'b1;
                    state_nxt  = RDONE;
                end
            end
            RDONE: begin
                if (!longest_stall)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_taken   <= 1'b0;
            sram_rdata <= '0;
        end else begin
            state <= state_nxt;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (!longest_stall)
                wr_taken <= 1'b0;
            else if (push)
                wr_taken <= 1'b1;
            if (rd_capture)
                sram_rdata <= rdata;
        end
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= sram_addr;
            mem_wdata[wr_ptr] <= sram_wdata;
            mem_size[wr_ptr]  <= wen_to_size(sram_wen);
        end
    end

endmodule

// File: doc/sram_like_bridge.md
SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter WBUF_DEPTH, default 4, meaning posted-write buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 sram_en  input  1  CPU-side access valid.
REQ-006 sram_wen  input  4  byte write enables; 0 = read.
REQ-007 sram_addr  input  AW  byte address.
REQ-008 sram_wdata  input  32  write data.
REQ-009 sram_rdata  output  32  read data returned to CPU.
REQ-010 stall  output  1  CPU must hold current access.
REQ-011 longest_stall  input  1  pipeline-wide freeze; CPU access held unchanged while 1.
REQ-012 req, wr  output  1 each  SRAM-like request valid, write flag.
REQ-013 size  output  2  0 = byte, 1 = half, 2 = word.
REQ-014 addr  output  AW  SRAM-like address.
REQ-015 wdata  output  32  SRAM-like write data.
REQ-016 addr_ok, data_ok  input  1 each  SRAM-like address accept, data complete.
REQ-017 rdata  input  32  SRAM-like read data.
REQ-018 wbuf_empty  output  1  posted-write buffer empty and no write on bus.

Function
REQ-019 Writes SHALL be posted: when sram_en & |sram_wen & ~full & ~wr_taken, push {addr, wdata, size} into FIFO that cycle with stall=0.
REQ-020 wr_taken SHALL set on a push while longest_stall=1 and clear when longest_stall=0, so a frozen write is pushed exactly once.
REQ-021 Write with FIFO full (and ~wr_taken) SHALL assert stall combinationally until a slot frees; push in the first cycle not full.
REQ-022 Size from sram_wen: 1111->2; 0011/1100->1; 0001/0010/0100/1000->0; any other nonzero->2.
REQ-023 Bus FSM states: IDLE, WADDR, WDATA, RADDR, RDATA, RDONE.
REQ-024 IDLE: FIFO non-empty -> WADDR (writes have priority); else pending read -> RADDR; else stay.
REQ-025 WADDR: req=1, wr=1, addr/size/wdata from FIFO head; addr_ok&data_ok -> pop, IDLE; addr_ok only -> WDATA.
REQ-026 WDATA: req=0; data_ok -> pop, IDLE.
REQ-027 RADDR: req=1, wr=0, size=2, addr=sram_addr; addr_ok&data_ok -> capture rdata, RDONE; addr_ok only -> RDATA.
REQ-028 RDATA: req=0; data_ok -> capture rdata into sram_rdata register, RDONE.
REQ-029 RDONE: stall=0, sram_rdata held; leave to IDLE in first cycle with longest_stall=0.
REQ-030 Read (sram_en & sram_wen==0) SHALL stall=1 from first cycle seen until the state is RDONE; read waits for FIFO to drain (read-after-write ordering).
REQ-031 Simultaneous push and pop SHALL keep count unchanged; count width clog2(WBUF_DEPTH)+1; pointers wrap modulo WBUF_DEPTH.
REQ-032 req SHALL stay asserted with stable addr/wr/size/wdata until addr_ok.
REQ-033 wbuf_empty = (count==0) & state not in {WADDR, WDATA}.
REQ-034 sram_en=0 SHALL produce stall=0 and no push.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, FIFO count/pointers 0, wr_taken=0, req=0, wr=0, size=0, addr=0, wdata=0, sram_rdata=0, stall=0, wbuf_empty=1.
REQ-036 Reset mid-transaction SHALL abandon the bus transfer and discard FIFO contents; no completion afterward.

Verification
REQ-037 Single word write 0x1000/0xDEADBEEF, addr_ok+data_ok same cycle -> stall=0, one bus write size=2, wbuf_empty returns 1.
REQ-038 Five back-to-back writes, addr_ok held 0 -> four pushed, fifth stalls until first pop, bus order preserved.
REQ-039 Write 0x2000 then read 0x2000 -> read stalls, bus write precedes read, sram_rdata=rdata after data_ok, stall drops the next cycle.
REQ-040 Write wen=1100 while longest_stall=1 for 3 cycles -> exactly one push, size=1.
REQ-041 Read with longest_stall=1 at data_ok -> RDONE held, sram_rdata stable until longest_stall=0.
REQ-042 rst=0 in WDATA with 2 entries queued -> req=0, count=0, wbuf_empty=1 immediately.
